register_file: RTL and testbench

//  Architectural register file with per-register rename tags; sits downstream of the RoB commit port and

---
 rtl/register_file.sv | 117 +++++++++++
 tb/tb_register_file.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags: combinational operand reads with
// commit bypass, RoB commit write-back, dispatcher rename and mispredict flush of all tags.
module register_file #(
  parameter int                    REG_WIDTH    = 5,
  parameter int                    EX_REG_WIDTH = 6,
  parameter logic [EX_REG_WIDTH-1:0] NON_REG    = 6'b100000,
  parameter int                    RoB_WIDTH    = 8,
  parameter int                    EX_RoB_WIDTH = 9,
  parameter logic [EX_RoB_WIDTH-1:0] NON_DEP    = 9'b100000000
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst_n,
  input  logic                    Sys_rdy,
  input  logic [EX_REG_WIDTH-1:0] DPRF_rs1,
  input  logic [EX_REG_WIDTH-1:0] DPRF_rs2,
  output logic [31:0]             RFDP_Vj,
  output logic [31:0]             RFDP_Vk,
  output logic [EX_RoB_WIDTH-1:0] RFDP_Qj,
  output logic [EX_RoB_WIDTH-1:0] RFDP_Qk,
  input  logic                    DPRF_en,
  input  logic [EX_REG_WIDTH-1:0] DPRF_rd,
  input  logic [RoB_WIDTH-1:0]    DPRF_RoB_index,
  input  logic                    RoBRF_pre_judge,
  input  logic                    RoBRF_en,
  input  logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  input  logic [EX_REG_WIDTH-1:0] RoBRF_rd,
  input  logic [31:0]             RoBRF_value
);

  localparam int NUM_REGS = 1 << REG_WIDTH;

  typedef struct packed {
    logic [31:0]             v;
    logic [EX_RoB_WIDTH-1:0] q;
  } read_t;

  logic [31:0]             value_q [NUM_REGS];
  logic [EX_RoB_WIDTH-1:0] tag_q   [NUM_REGS];

  logic                    commit_valid;
  logic                    rename_valid;
  logic [NUM_REGS-1:0]     commit_hit;
  logic [NUM_REGS-1:0]     rename_hit;
  logic [NUM_REGS-1:0]     tag_retire;
  read_t                   read_j;
  read_t                   read_k;

  // Entries with the top bit set denote "no register"; x0 is never a real destination
  assign commit_valid = RoBRF_en && !RoBRF_rd[EX_REG_WIDTH-1] &&
                        (RoBRF_rd[REG_WIDTH-1:0] != '0);
  assign rename_valid = DPRF_en && !DPRF_rd[EX_REG_WIDTH-1] &&
                        (DPRF_rd[REG_WIDTH-1:0] != '0);

  function automatic read_t read_port(input logic [EX_REG_WIDTH-1:0] rs);
    read_t r;
    logic [REG_WIDTH-1:0] idx;
    idx = rs[REG_WIDTH-1:0];
    r.v = '0;
    r.q = NON_DEP;
    if (!rs[EX_REG_WIDTH-1] && idx != '0) begin
      if (tag_q[idx] == NON_DEP) begin
        r.v = value_q[idx];
      end else if (RoBRF_en && RoBRF_rd == rs &&
                   RoBRF_RoB_index == tag_q[idx][RoB_WIDTH-1:0]) begin
        r.v = RoBRF_value;
      end else begin
        r.q = tag_q[idx];
      end
    end
    return r;
  endfunction

  always_comb begin
    read_j  = read_port(DPRF_rs1);
    read_k  = read_port(DPRF_rs2);
    RFDP_Vj = read_j.v;
    RFDP_Qj = read_j.q;
    RFDP_Vk = read_k.v;
    RFDP_Qk = read_k.q;
  end

  // A commit only retires the tag it produced; a younger rename of the same register survives
  always_comb begin
    commit_hit = '0;
    rename_hit = '0;
    tag_retire = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      commit_hit[i] = commit_valid && (RoBRF_rd[REG_WIDTH-1:0] == REG_WIDTH'(i));
      rename_hit[i] = rename_valid && (DPRF_rd[REG_WIDTH-1:0] == REG_WIDTH'(i));
      tag_retire[i] = commit_hit[i] && (tag_q[i] != NON_DEP) &&
                      (tag_q[i][RoB_WIDTH-1:0] == RoBRF_RoB_index);
    end
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= NON_DEP;
      end
    end else if (Sys_rdy) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (commit_hit[i]) begin
          value_q[i] <= RoBRF_value;
        end
        if (!RoBRF_pre_judge) begin
          tag_q[i] <= NON_DEP;
        end else if (rename_hit[i]) begin
          tag_q[i] <= {1'b0, DPRF_RoB_index};
        end else if (tag_retire[i]) begin
          tag_q[i] <= NON_DEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Randomized plus directed self-checking bench for register_file, compared against an
// array-based reference model of registers and rename tags.
module tb_register_file;

  localparam logic [5:0] NON_REG = 6'b100000;
  localparam logic [8:0] NON_DEP = 9'b100000000;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst_n;
  logic        Sys_rdy;
  logic [5:0]  DPRF_rs1, DPRF_rs2;
  logic [31:0] RFDP_Vj, RFDP_Vk;
  logic [8:0]  RFDP_Qj, RFDP_Qk;
  logic        DPRF_en;
  logic [5:0]  DPRF_rd;
  logic [7:0]  DPRF_RoB_index;
  logic        RoBRF_pre_judge;
  logic        RoBRF_en;
  logic [7:0]  RoBRF_RoB_index;
  logic [5:0]  RoBRF_rd;
  logic [31:0] RoBRF_value;

  logic [31:0] ref_value [32];
  logic [8:0]  ref_tag   [32];
  int          errors = 0;
  int          checks = 0;

  register_file dut (
    .Sys_clk(Sys_clk), .Sys_rst_n(Sys_rst_n), .Sys_rdy(Sys_rdy),
    .DPRF_rs1(DPRF_rs1), .DPRF_rs2(DPRF_rs2),
    .RFDP_Vj(RFDP_Vj), .RFDP_Vk(RFDP_Vk), .RFDP_Qj(RFDP_Qj), .RFDP_Qk(RFDP_Qk),
    .DPRF_en(DPRF_en), .DPRF_rd(DPRF_rd), .DPRF_RoB_index(DPRF_RoB_index),
    .RoBRF_pre_judge(RoBRF_pre_judge), .RoBRF_en(RoBRF_en),
    .RoBRF_RoB_index(RoBRF_RoB_index), .RoBRF_rd(RoBRF_rd), .RoBRF_value(RoBRF_value)
  );

  always #5 Sys_clk = ~Sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, observed, expected, $time);
    end
  endtask

  function automatic bit is_real(input logic [5:0] r);
    return !r[5] && r[4:0] != 5'd0;
  endfunction

  function automatic void expRead(input logic [5:0] rs, output logic [31:0] v,
                                  output logic [8:0] q);
    v = 32'd0;
    q = NON_DEP;
    if (is_real(rs)) begin
      if (ref_tag[rs[4:0]] == NON_DEP) v = ref_value[rs[4:0]];
      else if (RoBRF_en && RoBRF_rd == rs && RoBRF_RoB_index == ref_tag[rs[4:0]][7:0])
        v = RoBRF_value;
      else q = ref_tag[rs[4:0]];
    end
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 32; i++) begin
      ref_value[i] = 32'd0;
      ref_tag[i]   = NON_DEP;
    end
  endtask

  // Commit first, then flush or rename, so a same-cycle rename overrides the tag clear
  task automatic updateModel();
    if (Sys_rdy) begin
      if (RoBRF_en && is_real(RoBRF_rd)) begin
        ref_value[RoBRF_rd[4:0]] = RoBRF_value;
        if (ref_tag[RoBRF_rd[4:0]] != NON_DEP && ref_tag[RoBRF_rd[4:0]][7:0] == RoBRF_RoB_index)
          ref_tag[RoBRF_rd[4:0]] = NON_DEP;
      end
      if (!RoBRF_pre_judge) begin
        for (int i = 0; i < 32; i++) ref_tag[i] = NON_DEP;
      end else if (DPRF_en && is_real(DPRF_rd)) begin
        ref_tag[DPRF_rd[4:0]] = {1'b0, DPRF_RoB_index};
      end
    end
  endtask

  task automatic applyStimulus();
    logic [31:0] ev;
    logic [8:0]  eq;
    #1;
    expRead(DPRF_rs1, ev, eq);
    checkOutput("model_vj", RFDP_Vj, ev);
    checkOutput("model_qj", {23'd0, RFDP_Qj}, {23'd0, eq});
    expRead(DPRF_rs2, ev, eq);
    checkOutput("model_vk", RFDP_Vk, ev);
    checkOutput("model_qk", {23'd0, RFDP_Qk}, {23'd0, eq});
    @(posedge Sys_clk);
    updateModel();
    #1;
  endtask

  task automatic idle();
    Sys_rdy = 1'b1;  RoBRF_pre_judge = 1'b1;
    DPRF_rs1 = NON_REG; DPRF_rs2 = NON_REG;
    DPRF_en = 1'b0;  DPRF_rd = NON_REG; DPRF_RoB_index = 8'd0;
    RoBRF_en = 1'b0; RoBRF_rd = NON_REG; RoBRF_RoB_index = 8'd0; RoBRF_value = 32'd0;
  endtask

  // Both read ports look at the same register and must agree with fixed expectations
  task automatic peek(input string name, input logic [5:0] rs, input logic [31:0] ev,
                      input logic [8:0] eq);
    DPRF_rs1 = rs;
    DPRF_rs2 = rs;
    #1;
    checkOutput({name, "_vj"}, RFDP_Vj, ev);
    checkOutput({name, "_qj"}, {23'd0, RFDP_Qj}, {23'd0, eq});
    checkOutput({name, "_vk"}, RFDP_Vk, ev);
    checkOutput({name, "_qk"}, {23'd0, RFDP_Qk}, {23'd0, eq});
  endtask

  task automatic rename(input logic [5:0] rd, input logic [7:0] idx);
    idle();
    DPRF_en = 1'b1; DPRF_rd = rd; DPRF_RoB_index = idx;
    applyStimulus();
  endtask

  function automatic logic [5:0] randReg();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return NON_REG;
    if (r < 12) return 6'($urandom_range(0, 7));
    return 6'($urandom_range(0, 31));
  endfunction

  task automatic randomInputs();
    Sys_rdy         = ($urandom_range(0, 9) != 0);
    RoBRF_pre_judge = ($urandom_range(0, 19) != 0);
    DPRF_rs1        = randReg();
    DPRF_rs2        = randReg();
    DPRF_en         = 1'($urandom_range(0, 1));
    DPRF_rd         = randReg();
    DPRF_RoB_index  = 8'($urandom_range(0, 15));
    RoBRF_en        = 1'($urandom_range(0, 1));
    RoBRF_rd        = randReg();
    RoBRF_value     = $urandom;
    if ($urandom_range(0, 1) == 1 && is_real(RoBRF_rd))
      RoBRF_RoB_index = ref_tag[RoBRF_rd[4:0]][7:0];
    else
      RoBRF_RoB_index = 8'($urandom_range(0, 15));
  endtask

  initial begin
    idle();
    resetModel();
    Sys_rst_n = 1'b0;
    #12 Sys_rst_n = 1'b1;

    $display("[TB] reset state");
    DPRF_rs1 = 6'd5; DPRF_rs2 = 6'd31;
    #1;
    checkOutput("rst_vj", RFDP_Vj, 32'd0);
    checkOutput("rst_vk", RFDP_Vk, 32'd0);
    checkOutput("rst_qj", {23'd0, RFDP_Qj}, {23'd0, NON_DEP});
    checkOutput("rst_qk", {23'd0, RFDP_Qk}, {23'd0, NON_DEP});
    idle();
    applyStimulus();

    $display("[TB] rename, bypass and commit");
    rename(6'd3, 8'h12);
    idle();
    peek("t2_tagged", 6'd3, 32'd0, 9'h012);
    RoBRF_en = 1'b1; RoBRF_rd = 6'd3; RoBRF_RoB_index = 8'h12; RoBRF_value = 32'hDEADBEEF;
    peek("t2_bypass", 6'd3, 32'hDEADBEEF, NON_DEP);
    applyStimulus();
    idle();
    peek("t2_after", 6'd3, 32'hDEADBEEF, NON_DEP);
    applyStimulus();

    $display("[TB] stale commit keeps younger tag");
    rename(6'd7, 8'h01);
    rename(6'd7, 8'h02);
    idle();
    RoBRF_en = 1'b1; RoBRF_rd = 6'd7; RoBRF_RoB_index = 8'h01; RoBRF_value = 32'h55;
    applyStimulus();
    idle();
    peek("t3_tag", 6'd7, 32'd0, 9'h002);
    RoBRF_pre_judge = 1'b0;
    applyStimulus();
    idle();
    peek("t3_value", 6'd7, 32'h55, NON_DEP);
    applyStimulus();

    $display("[TB] same-cycle rename and commit");
    rename(6'd4, 8'h09);
    idle();
    RoBRF_en = 1'b1; RoBRF_rd = 6'd4; RoBRF_RoB_index = 8'h09; RoBRF_value = 32'hA;
    DPRF_en = 1'b1; DPRF_rd = 6'd4; DPRF_RoB_index = 8'h20;
    applyStimulus();
    idle();
    peek("t4_tag", 6'd4, 32'd0, 9'h020);
    RoBRF_pre_judge = 1'b0;
    applyStimulus();
    idle();
    peek("t4_value", 6'd4, 32'hA, NON_DEP);
    applyStimulus();

    $display("[TB] flush");
    rename(6'd1, 8'h41);
    rename(6'd2, 8'h42);
    rename(6'd3, 8'h43);
    idle();
    RoBRF_pre_judge = 1'b0;
    DPRF_en = 1'b1; DPRF_rd = 6'd5; DPRF_RoB_index = 8'h30;
    RoBRF_en = 1'b1; RoBRF_rd = 6'd1; RoBRF_RoB_index = 8'h41; RoBRF_value = 32'h77;
    applyStimulus();
    idle();
    peek("t5_r1", 6'd1, 32'h77, NON_DEP);
    peek("t5_r3", 6'd3, 32'hDEADBEEF, NON_DEP);
    peek("t5_r5", 6'd5, 32'd0, NON_DEP);
    applyStimulus();

    $display("[TB] x0 and no-register");
    idle();
    RoBRF_en = 1'b1; RoBRF_rd = 6'd0; RoBRF_value = 32'hFFFF;
    applyStimulus();
    rename(6'd0, 8'h05);
    rename(NON_REG, 8'h06);
    idle();
    peek("t6_x0", 6'd0, 32'd0, NON_DEP);
    peek("t6_nonreg", NON_REG, 32'd0, NON_DEP);
    applyStimulus();

    $display("[TB] stall holds state");
    idle();
    Sys_rdy = 1'b0;
    DPRF_en = 1'b1; DPRF_rd = 6'd8; DPRF_RoB_index = 8'h03;
    RoBRF_en = 1'b1; RoBRF_rd = 6'd1; RoBRF_RoB_index = 8'h00; RoBRF_value = 32'h123;
    applyStimulus();
    idle();
    peek("stall_r8", 6'd8, 32'd0, NON_DEP);
    peek("stall_r1", 6'd1, 32'h77, NON_DEP);
    applyStimulus();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      randomInputs();
      applyStimulus();
    end

    $display("[TB] asynchronous reset mid-operation");
    #2 Sys_rst_n = 1'b0;
    for (int r = 1; r < 32; r++) begin
      peek("areset", 6'(r), 32'd0, NON_DEP);
    end
    idle();
    resetModel();
    @(negedge Sys_clk);
    Sys_rst_n = 1'b1;
    @(posedge Sys_clk);
    #1;
    for (int n = 0; n < 200; n++) begin
      randomInputs();
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
